riscv_fetch_unit: RTL and testbench



---
 rtl/riscv_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: pipelined ROM requests, an in-order PC/instruction queue, and a redirect flush.
// Define FETCH_PERF_CNT_EN to add the perf_flush_cnt / perf_starve_cnt counters.
module riscv_fetch_unit #(
    parameter int                   BUS_WIDTH  = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [BUS_WIDTH-1:0] RESET_PC   = '0,
    parameter int                   PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [BUS_WIDTH-1:0]  redirect_pc,
    output logic                  rom_req_valid,
    input  logic                  rom_req_ready,
    output logic [BUS_WIDTH-1:0]  rom_address,
    input  logic                  rom_rsp_valid,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instruction,
    output logic [BUS_WIDTH-1:0]  if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_starve_cnt
`endif
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = PTR_W + 1;

    logic [BUS_WIDTH-1:0]  r_fetch_pc;
    logic [PTR_W-1:0]      r_alloc_ptr;
    logic [PTR_W-1:0]      r_fill_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_drop_cnt;
    logic [BUS_WIDTH-1:0]  r_pc_mem    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];

    logic                  w_full_alloc;
    logic                  w_req_fire;
    logic                  w_rsp_fill;
    logic                  w_rsp_drop;
    logic                  w_rsp_orphan;
    logic                  w_pop;
    logic [PTR_W-1:0]      w_inflight;
    logic [CNT_W-1:0]      w_drop_sum;
    logic [BUS_WIDTH-1:0]  w_fetch_pc_nxt;
    logic [PTR_W-1:0]      w_alloc_nxt;
    logic [PTR_W-1:0]      w_fill_nxt;
    logic [PTR_W-1:0]      w_rd_nxt;
    logic [PTR_W-1:0]      w_drop_nxt;

    assign w_full_alloc  = (r_alloc_ptr - r_rd_ptr) == PTR_W'(FIFO_DEPTH);
    assign w_inflight    = r_alloc_ptr - r_fill_ptr;
    assign rom_req_valid = !w_full_alloc && !rst;
    assign rom_address   = r_fetch_pc;
    assign w_req_fire    = rom_req_valid && rom_req_ready;

    // Stale responses are swallowed first; the queue only fills once drop_cnt has drained.
    assign w_rsp_drop    = rom_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_fill    = rom_rsp_valid && (r_drop_cnt == '0) && (w_inflight != '0);
    assign w_rsp_orphan  = rom_rsp_valid && (r_drop_cnt == '0) && (w_inflight == '0);

    assign if_valid      = r_fill_ptr != r_rd_ptr;
    assign w_pop         = if_valid && if_ready;

    // Every request still owed a response after this edge, including one accepted right now.
    assign w_drop_sum    = {1'b0, r_drop_cnt} + {1'b0, w_inflight} + CNT_W'(w_req_fire)
                         - CNT_W'(w_rsp_fill || w_rsp_drop);

    // Masked so decode sees zeros while the queue is empty, including straight out of reset.
    assign if_instruction = if_valid ? r_instr_mem[r_rd_ptr[IDX_W-1:0]] : '0;
    assign if_pc          = if_valid ? r_pc_mem[r_rd_ptr[IDX_W-1:0]]    : '0;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_alloc_nxt    = r_alloc_ptr;
        w_fill_nxt     = r_fill_ptr;
        w_rd_nxt       = r_rd_ptr;
        w_drop_nxt     = r_drop_cnt;
        if (redirect_valid) begin
            w_alloc_nxt    = r_alloc_ptr + PTR_W'(w_req_fire);
            w_fill_nxt     = w_alloc_nxt;
            w_rd_nxt       = w_alloc_nxt;
            w_drop_nxt     = w_drop_sum[PTR_W-1:0];
            w_fetch_pc_nxt = redirect_pc;
        end else begin
            if (w_req_fire) begin
                w_alloc_nxt    = r_alloc_ptr + 1'b1;
                w_fetch_pc_nxt = r_fetch_pc + BUS_WIDTH'(PC_STEP);
            end
            if (w_rsp_fill) begin
                w_fill_nxt = r_fill_ptr + 1'b1;
            end
            if (w_rsp_drop) begin
                w_drop_nxt = r_drop_cnt - 1'b1;
            end
            if (w_pop) begin
                w_rd_nxt = r_rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_alloc_ptr <= w_alloc_nxt;
            r_fill_ptr  <= w_fill_nxt;
            r_rd_ptr    <= w_rd_nxt;
            r_drop_cnt  <= w_drop_nxt;
        end
    end

    // NOTE: queue storage is not reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_pc_mem[r_alloc_ptr[IDX_W-1:0]] <= r_fetch_pc;
        end
        if (w_rsp_fill) begin
            r_instr_mem[r_fill_ptr[IDX_W-1:0]] <= rom_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_flush_cnt;
    logic [31:0] r_perf_starve_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_flush_cnt  <= '0;
            r_perf_starve_cnt <= '0;
        end else begin
            if (redirect_valid && (r_perf_flush_cnt != '1)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
            if (if_ready && !if_valid && (r_perf_starve_cnt != '1)) begin
                r_perf_starve_cnt <= r_perf_starve_cnt + 32'd1;
            end
        end
    end

    assign perf_flush_cnt  = r_perf_flush_cnt;
    assign perf_starve_cnt = r_perf_starve_cnt;
`endif

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst) !w_rsp_orphan);

    a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
        redirect_valid |-> (w_drop_sum <= CNT_W'(FIFO_DEPTH)));

    a_addr_hold: assert property (@(posedge clk) disable iff (rst)
        (rom_req_valid && !rom_req_ready && !redirect_valid) |=> $stable(rom_address));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: a latency-configurable ROM model feeds the DUT and a monitor
// compares every decode handshake against the queue of PCs the bench expects to see delivered.
module tb_riscv_fetch_unit;

    localparam int          BW     = 32;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [BW-1:0] redirect_pc = '0;
    logic          rom_req_valid;
    logic          rom_req_ready = 1'b0;
    logic [BW-1:0] rom_address;
    logic          rom_rsp_valid = 1'b0;
    logic [DW-1:0] rom_rdata = '0;
    logic          if_valid;
    logic          if_ready = 1'b0;
    logic [DW-1:0] if_instruction;
    logic [BW-1:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_flush_cnt;
    logic [31:0]   perf_starve_cnt;
`endif

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .BUS_WIDTH (BW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (RST_PC),
        .PC_STEP   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .rom_req_valid (rom_req_valid),
        .rom_req_ready (rom_req_ready),
        .rom_address   (rom_address),
        .rom_rsp_valid (rom_rsp_valid),
        .rom_rdata     (rom_rdata),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instruction(if_instruction),
        .if_pc         (if_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rom_txn_t;

    rom_txn_t    rom_q[$];
    logic [31:0] exp_q[$];

    int          n_vec    = 0;
    int          n_miss   = 0;
    int          n_pop    = 0;
    int          n_accept = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] exp_fetch_pc = RST_PC;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    logic        obs_req_valid;
    logic        obs_if_valid;
    logic [31:0] obs_if_pc;
    logic [31:0] obs_if_instr;
    logic [31:0] obs_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left on a negedge. Inputs for the coming posedge are already set.
    task automatic cycle();
        rom_txn_t t;
        if (!rst && rom_q.size() > 0 && rom_q[0].due <= cyc) begin
            t             = rom_q.pop_front();
            rom_rsp_valid = 1'b1;
            rom_rdata     = t.addr;
        end else begin
            rom_rsp_valid = 1'b0;
            rom_rdata     = '0;
        end
        #1;
        obs_req_valid = rom_req_valid;
        obs_if_valid  = if_valid;
        obs_if_pc     = if_pc;
        obs_if_instr  = if_instruction;
        obs_addr      = rom_address;
        if (prev_wait) check("addr_stable", rom_address, prev_addr);
        prev_wait = rom_req_valid && !rom_req_ready && !redirect_valid && !rst;
        prev_addr = rom_address;
        if (rom_req_valid && rom_req_ready) begin
            n_accept++;
            check("req_addr", rom_address, exp_fetch_pc);
            t.addr = rom_address;
            t.due  = cyc + lat;
            rom_q.push_back(t);
            if (!redirect_valid) begin
                exp_q.push_back(exp_fetch_pc);
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
        #2;
        if (rst) begin
            exp_q.delete();
            rom_q.delete();
            exp_fetch_pc = RST_PC;
            prev_wait    = 1'b0;
        end else if (redirect_valid) begin
            exp_q.delete();
            exp_fetch_pc = redirect_pc;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Monitor: runs after the monitor slot of every cycle's own bookkeeping and before any flush.
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (if_valid && if_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_delivery: got pc=%0h, want no delivery", if_pc);
            end else begin
                e = exp_q.pop_front();
                check("if_pc", if_pc, e);
                check("if_instruction", if_instruction, e);
            end
        end
    end

    task automatic reset_dut();
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hDEAD_BEE0;
        rom_req_ready  = 1'b1;
        if_ready       = 1'b0;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("rst_req_valid", obs_req_valid, 0);
        check("rst_if_valid", obs_if_valid, 0);
        check("rst_if_pc", obs_if_pc, 0);
        check("rst_if_instr", obs_if_instr, 0);
        check("rst_rom_address", obs_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_flush", perf_flush_cnt, 0);
        check("rst_perf_starve", perf_starve_cnt, 0);
`endif
        rst = 1'b0;
    endtask

    task automatic drain();
        rom_req_ready  = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || rom_q.size() != 0); i++) cycle();
        check("drain_exp_empty", exp_q.size(), 0);
    endtask

    initial begin
        int first_k;
        int cnt;
        int base;

        @(negedge clk);

        // Latency-1 ROM, decode always ready: one instruction per cycle from cycle 2.
        reset_dut();
        lat = 1; rom_req_ready = 1'b1; if_ready = 1'b1;
        first_k = -1;
        base    = n_pop;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (obs_if_valid && first_k < 0) first_k = k;
        end
        check("t1_first_valid_cycle", first_k, 2);
        check("t1_pops", n_pop - base, 10);
        drain();

        // Decode stalled: the queue bounds accepted requests at FIFO_DEPTH.
        reset_dut();
        lat = 1; rom_req_ready = 1'b1; if_ready = 1'b0;
        base = n_accept;
        for (int k = 0; k < 10; k++) cycle();
        check("t2_accepts", n_accept - base, 4);
        check("t2_req_valid_full", obs_req_valid, 0);
        if_ready = 1'b1; rom_req_ready = 1'b0;
        base = n_pop;
        for (int k = 0; k < 4; k++) cycle();
        check("t2_release_pops", n_pop - base, 4);
        drain();

        // Latency 3, redirect with three requests in flight (last accepted in the redirect cycle).
        reset_dut();
        lat = 3; rom_req_ready = 1'b1; if_ready = 1'b1;
        cycle(); cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (obs_if_valid) cnt++;
        end
        check("t3_no_stale_valid", cnt, 0);
        cycle();
        check("t3_valid_after_drops", obs_if_valid, 1);
        check("t3_first_pc", obs_if_pc, 32'h0000_0100);
`ifdef FETCH_PERF_CNT_EN
        check("t3_perf_flush", perf_flush_cnt, 1);
        check("t3_perf_starve", perf_starve_cnt, 7);
`endif
        drain();

        // Redirect coinciding with a response and a request accept.
        reset_dut();
        lat = 2; rom_req_ready = 1'b1; if_ready = 1'b1;
        cycle(); cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (obs_if_valid) cnt++;
        end
        check("t4_no_stale_valid", cnt, 0);
        cycle();
        check("t4_valid", obs_if_valid, 1);
        check("t4_first_pc", obs_if_pc, 32'h0000_0200);
        check("t4_first_instr", obs_if_instr, 32'h0000_0200);
        drain();

        // Back-to-back redirects accumulate the drop count.
        reset_dut();
        lat = 2; rom_req_ready = 1'b1; if_ready = 1'b1;
        cycle(); cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect_pc = 32'h0000_0300;
        cycle();
        redirect_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (obs_if_valid) cnt++;
        end
        check("t5_no_stale_valid", cnt, 0);
        cycle();
        check("t5_valid", obs_if_valid, 1);
        check("t5_first_pc", obs_if_pc, 32'h0000_0300);
        drain();

        // Random ROM backpressure and decode stalls with occasional redirects.
        reset_dut();
        lat = 2;
        for (int k = 0; k < 150; k++) begin
            rom_req_ready  = 1'($urandom_range(0, 1));
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'($urandom_range(0, 4095)) << 2;
            cycle();
        end
        drain();

        // Reset mid-stream with requests outstanding, then restart from RESET_PC.
        reset_dut();
        lat = 3; rom_req_ready = 1'b1; if_ready = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        reset_dut();
        lat = 1; rom_req_ready = 1'b1; if_ready = 1'b1;
        first_k = -1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (obs_if_valid && first_k < 0) begin
                first_k = k;
                check("t7_restart_pc", obs_if_pc, RST_PC);
            end
        end
        check("t7_restart_cycle", first_k, 2);
        drain();

        cycle(); cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
